encrypt_arbiter: RTL and testbench

//  Shares one encryption6b cipher core between two byte requesters (port 0, port 1).

---
 rtl/encrypt_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_encrypt_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_arbiter.sv
// encrypt_arbiter: shares one encryption6b cipher core between two byte
// requesters using round-robin grant. Each accepted byte is driven into the
// core (load), the arbiter waits for the core to report ready, then captures
// the ciphertext and key and pulses the result back to the granted requester.
// Optional feature macro: ENC_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts an operation after TIMEOUT cycles and pulses timeout_err.
module encrypt_arbiter #(
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ack,
  output logic       res0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ack,
  output logic       res1_valid,
  output logic [7:0] res0_data,
  output logic [7:0] res1_data,
  output logic [5:0] res_key,
  output logic       busy,
  output logic       eng_load,
  output logic [7:0] eng_datain,
  input  logic [7:0] eng_dataout,
  input  logic       eng_ready,
`ifdef ENC_TIMEOUT_EN
  input  logic [5:0] eng_key,
  output logic       timeout_err
`else
  input  logic [5:0] eng_key
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LoadLast = 4'(LOAD_CYCLES);

  // Reject parameter values the load counter or watchdog cannot represent.
  if (LOAD_CYCLES < 1 || LOAD_CYCLES > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("encrypt_arbiter: LOAD_CYCLES must be 1..15 and TIMEOUT >= 1");
  end

  state_t     state_q;
  logic       grant_q;
  logic       prio_q;
  logic [3:0] load_cnt_q;
  logic       first_wait_q;
  logic       eng_load_q;
  logic [7:0] eng_datain_q;
  logic       res0_valid_q;
  logic       res1_valid_q;
  logic [7:0] res0_data_q;
  logic [7:0] res1_data_q;
  logic [5:0] res_key_q;

  logic       accept_d;
  logic       grant_d;
  logic [7:0] req_data_d;

`ifdef ENC_TIMEOUT_EN
  localparam int WaitCntW = $clog2(TIMEOUT) + 1;
  localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(TIMEOUT - 1);
  logic [WaitCntW-1:0] wait_cnt_q;
  logic                timeout_err_q;
`endif

  // Grant decision in IDLE: a lone requester always wins, and when both are
  // valid the port that was not served last (prio_q) wins.
  always_comb begin
    accept_d   = 1'b0;
    grant_d    = 1'b0;
    req_data_d = 8'h00;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        accept_d = 1'b1;
        grant_d  = prio_q;
      end else if (req0_valid) begin
        accept_d = 1'b1;
        grant_d  = 1'b0;
      end else if (req1_valid) begin
        accept_d = 1'b1;
        grant_d  = 1'b1;
      end
      req_data_d = grant_d ? req1_data : req0_data;
    end
  end

  // Main sequencer: load the core, wait for ready (skipping the first WAIT
  // cycle so a ready left over from the previous byte is never captured),
  // capture the result, then pulse it back and rotate the priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      prio_q        <= 1'b0;
      load_cnt_q    <= 4'd0;
      first_wait_q  <= 1'b0;
      eng_load_q    <= 1'b0;
      eng_datain_q  <= 8'h00;
      res0_valid_q  <= 1'b0;
      res1_valid_q  <= 1'b0;
      res0_data_q   <= 8'h00;
      res1_data_q   <= 8'h00;
      res_key_q     <= 6'h00;
`ifdef ENC_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            grant_q      <= grant_d;
            eng_datain_q <= req_data_d;
            eng_load_q   <= 1'b1;
            load_cnt_q   <= 4'd1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_cnt_q == LoadLast) begin
            eng_load_q   <= 1'b0;
            first_wait_q <= 1'b1;
`ifdef ENC_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
            state_q      <= S_WAIT;
          end else begin
            load_cnt_q <= load_cnt_q + 4'd1;
          end
        end
        S_WAIT: begin
          first_wait_q <= 1'b0;
          if (!first_wait_q && eng_ready) begin
            if (grant_q) begin
              res1_data_q  <= eng_dataout;
              res1_valid_q <= 1'b1;
            end else begin
              res0_data_q  <= eng_dataout;
              res0_valid_q <= 1'b1;
            end
            res_key_q    <= eng_key;
            eng_datain_q <= 8'h00;
            state_q      <= S_DONE;
          end
`ifdef ENC_TIMEOUT_EN
          else if (wait_cnt_q == WaitLast) begin
            timeout_err_q <= 1'b1;
            eng_datain_q  <= 8'h00;
            state_q       <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          res0_valid_q  <= 1'b0;
          res1_valid_q  <= 1'b0;
`ifdef ENC_TIMEOUT_EN
          timeout_err_q <= 1'b0;
`endif
          prio_q        <= ~grant_q;
          state_q       <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ack   = accept_d && !grant_d;
  assign req1_ack   = accept_d && grant_d;
  assign res0_valid = res0_valid_q;
  assign res1_valid = res1_valid_q;
  assign res0_data  = res0_data_q;
  assign res1_data  = res1_data_q;
  assign res_key    = res_key_q;
  assign busy       = (state_q != S_IDLE);
  assign eng_load   = eng_load_q;
  assign eng_datain = eng_datain_q;
`ifdef ENC_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_encrypt_arbiter.sv
// tb_encrypt_arbiter: directed bench for encrypt_arbiter with a small cipher
// core model (ciphertext = plaintext ^ 8'h5A) and a scoreboard queue that a
// separate monitor drains whenever a result pulse appears.
module tb_encrypt_arbiter;

  localparam int LoadCycles = 2;
  localparam int Timeout    = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0Valid = 1'b0;
  logic [7:0] req0Data = 8'h00;
  logic       req1Valid = 1'b0;
  logic [7:0] req1Data = 8'h00;
  logic       req0Ack, req1Ack, res0Valid, res1Valid, busy, engLoad, engReady;
  logic [7:0] res0Data, res1Data, engDatain, engDataout;
  logic [5:0] resKey;
  logic [5:0] engKey = 6'h15;
`ifdef ENC_TIMEOUT_EN
  logic       timeoutErr;
`endif

  typedef struct {
    bit         port;
    logic [7:0] data;
    logic [5:0] key;
    int         ackCycle;
    int         lat;
    int         kind;
  } exp_t;

  exp_t sbQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   cycle = 0;
  int   loadRun = 0;
  int   readyMode = 0;
  int   readyDelay = 0;
  int   readyCnt = 0;
  logic [7:0] modelByte = 8'h00;

  encrypt_arbiter #(.LOAD_CYCLES(LoadCycles), .TIMEOUT(Timeout)) dut (
    .clk(clock),
    .rst(reset),
    .req0_valid(req0Valid),
    .req0_data(req0Data),
    .req0_ack(req0Ack),
    .res0_valid(res0Valid),
    .req1_valid(req1Valid),
    .req1_data(req1Data),
    .req1_ack(req1Ack),
    .res1_valid(res1Valid),
    .res0_data(res0Data),
    .res1_data(res1Data),
    .res_key(resKey),
    .busy(busy),
    .eng_load(engLoad),
    .eng_datain(engDatain),
    .eng_dataout(engDataout),
    .eng_ready(engReady),
`ifdef ENC_TIMEOUT_EN
    .timeout_err(timeoutErr),
`endif
    .eng_key(engKey)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Cycle index used to measure ack-to-result latency.
  always @(posedge clock) cycle <= cycle + 1;

  // Cipher core model: latches the byte while load is high, then counts
  // cycles since load so ready can be stuck high, delayed, or stuck low.
  always @(posedge clock) begin
    if (engLoad) begin
      modelByte <= engDatain;
      readyCnt  <= 0;
    end else if (readyCnt < 1000) begin
      readyCnt <= readyCnt + 1;
    end
  end

  assign engDataout = modelByte ^ 8'h5A;
  assign engReady   = (readyMode == 0) ? 1'b1 :
                      (readyMode == 1) ? (!engLoad && readyCnt >= readyDelay) : 1'b0;

  // Shared comparison helper: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pulse exclusivity, load length, and scoreboard pops on results.
  always @(negedge clock) begin
    int pulses;
    exp_t e;
    if (reset) begin
      loadRun = 0;
    end else begin
      pulses = int'(req0Ack) + int'(req1Ack) + int'(res0Valid) + int'(res1Valid);
      if (pulses != 0) checkOutput("onePulse", pulses, 1);
      if (engLoad) begin
        loadRun++;
      end else if (loadRun != 0) begin
        checkOutput("loadLen", loadRun, LoadCycles);
        loadRun = 0;
      end
      if (res0Valid || res1Valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedRes", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("resKind", 0, e.kind);
          checkOutput("resPort", res1Valid, e.port);
          checkOutput("resData", res1Valid ? res1Data : res0Data, e.data);
          checkOutput("resKey", resKey, e.key);
          checkOutput("resLatency", cycle - e.ackCycle, e.lat);
        end
      end
`ifdef ENC_TIMEOUT_EN
      if (timeoutErr) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedTimeout", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("toKind", 1, e.kind);
          checkOutput("toLatency", cycle - e.ackCycle, e.lat);
        end
      end
`endif
    end
  end

  // Push one scoreboard entry for a just-acked request.
  task automatic pushExp(input bit port, input logic [7:0] expData, input int lat, input int kind);
    exp_t e;
    e.port = port;
    e.data = expData;
    e.key = engKey;
    e.ackCycle = cycle;
    e.lat = lat;
    e.kind = kind;
    sbQ.push_back(e);
  endtask

  // Single requester: raise valid, wait (bounded) for its ack, then drop.
  task automatic applyStimulus(input bit port, input logic [7:0] data, input logic [7:0] expData, input int lat);
    bit acked = 0;
    @(posedge clock); #1;
    if (port) begin req1Valid = 1'b1; req1Data = data; end
    else begin req0Valid = 1'b1; req0Data = data; end
    for (int i = 0; i < 300 && !acked; i++) begin
      @(negedge clock);
      if (port ? req1Ack : req0Ack) begin
        acked = 1;
        pushExp(port, expData, lat, 0);
      end
    end
    if (!acked) checkOutput("ackTimeout", 0, 1);
    @(posedge clock); #1;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  // Both requesters held valid: acks must alternate starting at firstPort.
  task automatic applyBoth(input logic [7:0] d0, input logic [7:0] e0, input logic [7:0] d1, input logic [7:0] e1,
                           input int n, input bit firstPort, input int lat, input int kind);
    int acks = 0;
    bit expPort = firstPort;
    bit got;
    @(posedge clock); #1;
    req0Valid = 1'b1; req0Data = d0;
    req1Valid = 1'b1; req1Data = d1;
    for (int i = 0; i < 600 && acks < n; i++) begin
      @(negedge clock);
      if (req0Ack || req1Ack) begin
        got = req1Ack;
        checkOutput("rrOrder", got, expPort);
        pushExp(got, got ? e1 : e0, lat, kind);
        expPort = ~expPort;
        acks++;
      end
    end
    if (acks < n) checkOutput("bothAckTimeout", acks, n);
    @(posedge clock); #1;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  // Bounded wait for every outstanding result and an idle arbiter.
  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      if (sbQ.size() == 0 && !busy) done = 1;
    end
    if (!done) checkOutput("idleTimeout", 0, 1);
  endtask

  // Directed test sequence.
  initial begin
    // Reset, then idle with no requests: everything stays at zero.
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstAck0", req0Ack, 0);
    checkOutput("rstAck1", req1Ack, 0);
    checkOutput("rstRes0Valid", res0Valid, 0);
    checkOutput("rstRes1Valid", res1Valid, 0);
    checkOutput("rstEngLoad", engLoad, 0);
    checkOutput("rstEngDatain", engDatain, 0);
    checkOutput("rstRes0Data", res0Data, 0);
    checkOutput("rstRes1Data", res1Data, 0);
    checkOutput("rstResKey", resKey, 0);
`ifdef ENC_TIMEOUT_EN
    checkOutput("rstTimeoutErr", timeoutErr, 0);
`endif

    // Port 0 alone, ready stuck high: result five cycles after ack.
    readyMode = 0;
    engKey = 6'h15;
    applyStimulus(1'b0, 8'h00, 8'h5A, 5);
    waitIdle();

    // Port 1 alone, ready arrives 10 cycles after load ends.
    readyMode = 1;
    readyDelay = 10;
    engKey = 6'h2A;
    applyStimulus(1'b1, 8'hC3, 8'h99, 14);
    waitIdle();

    // Both held valid: acks alternate 0,1,0,1.
    readyMode = 0;
    engKey = 6'h15;
    applyBoth(8'hA5, 8'hFF, 8'h3C, 8'h66, 4, 1'b0, 5, 0);
    waitIdle();

    // Serve port 0 so port 1 becomes preferred, then abort a port 1
    // operation with reset in WAIT; afterwards port 0 must be preferred.
    applyStimulus(1'b0, 8'h0F, 8'h55, 5);
    waitIdle();
    readyMode = 2;
    @(posedge clock); #1;
    req1Valid = 1'b1;
    req1Data = 8'h77;
    begin
      bit acked = 0;
      for (int i = 0; i < 50 && !acked; i++) begin
        @(negedge clock);
        if (req1Ack) acked = 1;
      end
      checkOutput("abortAck", acked, 1);
    end
    @(posedge clock); #1;
    req1Valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 checkOutput("abortBusyBefore", busy, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("abortEngLoad", engLoad, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortEngDatain", engDatain, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    readyMode = 0;
    applyBoth(8'h11, 8'h4B, 8'h22, 8'h78, 2, 1'b0, 5, 0);
    waitIdle();

`ifdef ENC_TIMEOUT_EN
    // Ready stuck low: each operation aborts after Timeout WAIT cycles and
    // the pending other port is granted next.
    readyMode = 2;
    applyBoth(8'h01, 8'h00, 8'h02, 8'h00, 2, 1'b0, 3 + Timeout, 1);
    waitIdle();
    readyMode = 0;
`endif

    repeat (4) @(negedge clock);
    checkOutput("sbEmpty", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
